conv_kxk_mac: RTL and testbench
===============================

CONV_KXK_MAC -- requirements
Module: conv_kxk_mac

Interface
REQ-001 SHALL have parameter WI, default 8, signed input and weight width.
REQ-002 SHALL have parameter K, default 3, odd kernel side (3..7).
REQ-003 SHALL have parameter CIN, default 4, input channels accumulated per output.
REQ-004 SHALL have parameters BW 32 (bias width), ACCW 32 (accumulator width), OUTW 16 (output width), SHIFT 0 (arithmetic right shift before saturation).
REQ-005 SHALL have port iClk, in, 1, single clock for all logic, rising edge.
REQ-006 SHALL have port iRst, in, 1, reset, asynchronous and active-high.
REQ-007 SHALL have port iClear, in, 1, synchronous clear of channel counter, pipeline valids and error flag.
REQ-008 SHALL have port iInValid, in, 1, window beat valid.
REQ-009 SHALL have port iWindow, in, K*K*WI, flattened window; row-major; element (0,0) in the MSBs.
REQ-010 SHALL have port iRelu, in, 1, runtime ReLU enable, sampled with the last-channel beat.
REQ-011 SHALL have ports iWeightWe in 1, iWeightAddr in clog2(CIN*K*K), iWeightData in WI; weight write, address = c*K*K + r*K + col.
REQ-012 SHALL have ports iBiasWe in 1, iBiasData in BW; bias write.
REQ-013 SHALL have ports oOutValid out 1, oOutData out OUTW signed, oSat out 1 (result saturated), oBusy out 1, oCfgErr out 1 (sticky).

Function
REQ-014 Each valid beat SHALL be consumed as channel ch_cnt; ch_cnt SHALL increment per beat and wrap CIN-1 -> 0; gaps in iInValid SHALL hold ch_cnt and the accumulator.
REQ-015 Stage 1 (edge ending beat cycle t) SHALL register K*K signed products of width 2*WI.
REQ-016 Stage 2 SHALL register the sign-extended adder-tree sum at ACCW.
REQ-017 Stage 3 SHALL set acc = tree when the beat was channel 0, else acc + tree; wrap-around at ACCW, no overflow detection.
REQ-018 For the channel CIN-1 beat, stage 3 SHALL compute y = (acc_next + sext(bias)) >>> SHIFT, then y = 0 if iRelu and y < 0, then saturate to the signed OUTW range; oSat = 1 iff clamped.
REQ-019 Last-channel beat in cycle t SHALL give oOutValid = 1 in cycle t+3 for exactly one cycle; oOutData and oSat SHALL hold their value until the next result.
REQ-020 Back-to-back beats SHALL be accepted every cycle with no stall; throughput is one output per CIN beats.
REQ-021 oBusy SHALL be 1 while ch_cnt != 0 or any pipeline stage holds a valid beat.
REQ-022 Weight/bias writes with oBusy = 0 SHALL take effect from the next cycle.
REQ-023 Weight/bias writes with oBusy = 1 SHALL be ignored and SHALL set oCfgErr.
REQ-024 Simultaneous iInValid and a write with oBusy = 0 SHALL ignore the write, set oCfgErr, and process the beat with the old weights.
REQ-025 iClear SHALL take priority over iInValid in the same cycle; the beat is dropped, and weights and bias are retained.

Reset
REQ-026 iRst SHALL asynchronously force oOutValid = 0, oOutData = 0, oSat = 0, oCfgErr = 0, oBusy = 0, ch_cnt = 0, acc = 0 and all stage valids = 0.
REQ-027 Weights and bias SHALL reset to 0.
REQ-028 Reset mid-accumulation SHALL discard the partial sum; no oOutValid SHALL follow for pre-reset beats.

Structure
REQ-029 A shared package SHALL hold the default widths, clog2 address-width helper and OUTW saturation min/max constants.
REQ-030 One sub-module SHALL exist: conv_adder_tree (K*K products -> registered ACCW sum).
REQ-031 Weights SHALL be held in registers, not inferred RAM, with no file initialisation.

Verification (K=3, CIN=2, WI=8, OUTW=16, SHIFT=0)
REQ-032 Reset: assert iRst mid-stream -> all outputs 0 immediately; no result for the partial window.
REQ-033 All weights 1, bias 0, two beats of all-ones -> oOutData = 18, oOutValid exactly 3 cycles after the second beat.
REQ-034 Weights -1, bias 0, inputs 10 -> -180 with iRelu = 0; 0 with iRelu = 1; oSat = 0.
REQ-035 Weights 127, inputs 127 (sum 290322) -> oOutData = 32767, oSat = 1; weights -128, inputs 127 -> -32768, oSat = 1.
REQ-036 Four consecutive beats with a one-cycle iInValid gap after beat 1 -> two results, each correct and independent; accumulator restarts on channel 0.
REQ-037 Weight write while oBusy = 1 -> weights unchanged, oCfgErr = 1 until iClear; write after idle -> new result reflects the new weight.

Source files
------------

// File: rtl/conv_kxk_mac_pkg.sv
// Shared defaults and helpers for the KxK convolution MAC: widths, address
// width helper and signed saturation bounds.
package conv_kxk_mac_pkg;

  localparam int WI_DEF    = 8;
  localparam int K_DEF     = 3;
  localparam int CIN_DEF   = 4;
  localparam int BW_DEF    = 32;
  localparam int ACCW_DEF  = 32;
  localparam int OUTW_DEF  = 16;
  localparam int SHIFT_DEF = 0;

  // Never returns 0 so a one-entry space still gets a 1-bit address.
  function automatic int clog2_addr(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic longint sat_max(input int w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

  localparam longint OUT_MAX_DEF = sat_max(OUTW_DEF);
  localparam longint OUT_MIN_DEF = sat_min(OUTW_DEF);

endpackage

// File: rtl/conv_adder_tree.sv
// Sums N signed products into one sign-extended ACCW result, registered when
// iEn is high and held otherwise.
module conv_adder_tree
  import conv_kxk_mac_pkg::*;
#(
  parameter int N    = 9,
  parameter int PW   = 16,
  parameter int ACCW = ACCW_DEF
) (
  input  logic                   iClk,
  input  logic                   iRst,
  input  logic                   iEn,
  input  logic [N*PW-1:0]        iProd,
  output logic signed [ACCW-1:0] oSum
);

  logic signed [ACCW-1:0] sum_d, sum_q;

  always_comb begin
    sum_d = sum_q;
    if (iEn) begin
      sum_d = '0;
      for (int i = 0; i < N; i++) begin
        sum_d = sum_d + ACCW'($signed(iProd[i*PW +: PW]));
      end
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) sum_q <= '0;
    else      sum_q <= sum_d;
  end

  assign oSum = sum_q;

endmodule

// File: rtl/conv_kxk_mac.sv
// KxK multi-channel convolution MAC: product stage, adder-tree stage, then
// channel accumulation with bias, shift, optional ReLU and saturation.
module conv_kxk_mac
  import conv_kxk_mac_pkg::*;
#(
  parameter int WI    = WI_DEF,
  parameter int K     = K_DEF,
  parameter int CIN   = CIN_DEF,
  parameter int BW    = BW_DEF,
  parameter int ACCW  = ACCW_DEF,
  parameter int OUTW  = OUTW_DEF,
  parameter int SHIFT = SHIFT_DEF
) (
  input  logic                               iClk,
  input  logic                               iRst,
  input  logic                               iClear,
  input  logic                               iInValid,
  input  logic [K*K*WI-1:0]                  iWindow,
  input  logic                               iRelu,
  input  logic                               iWeightWe,
  input  logic [clog2_addr(CIN*K*K)-1:0]     iWeightAddr,
  input  logic [WI-1:0]                      iWeightData,
  input  logic                               iBiasWe,
  input  logic [BW-1:0]                      iBiasData,
  output logic                               oOutValid,
  output logic signed [OUTW-1:0]             oOutData,
  output logic                               oSat,
  output logic                               oBusy,
  output logic                               oCfgErr
);

  localparam int NT = K * K;
  localparam int NW = CIN * NT;
  localparam int AW = clog2_addr(NW);
  localparam int CW = clog2_addr(CIN);
  localparam int PW = 2 * WI;
  localparam longint OUT_MAX = sat_max(OUTW);
  localparam longint OUT_MIN = sat_min(OUTW);

  // Handshake: iInValid has no ready; a beat is taken in every cycle it is
  // high unless iClear is also high. oOutValid is a one-cycle strobe.

  logic signed [WI-1:0]   w_q [NW];
  logic signed [WI-1:0]   w_d [NW];
  logic signed [BW-1:0]   bias_q, bias_d;
  logic [CW-1:0]          ch_q, ch_d;
  logic                   s1_v_q, s1_v_d, s1_first_q, s1_first_d;
  logic                   s1_last_q, s1_last_d, s1_relu_q, s1_relu_d;
  logic signed [PW-1:0]   prod_q [NT];
  logic signed [PW-1:0]   prod_d [NT];
  logic [NT*PW-1:0]       prod_flat;
  logic                   s2_v_q, s2_v_d, s2_first_q, s2_first_d;
  logic                   s2_last_q, s2_last_d, s2_relu_q, s2_relu_d;
  logic signed [ACCW-1:0] tree_sum, acc_q, acc_d, acc_next;
  logic signed [ACCW-1:0] biased, shifted, rectified;
  logic                   out_valid_q, out_valid_d, sat_q, sat_d, err_q, err_d;
  logic signed [OUTW-1:0] out_data_q, out_data_d;
  logic                   busy, beat, cfg_ok;
  logic [WI-1:0]          a_e, b_e;

  assign busy   = (ch_q != '0) || s1_v_q || s2_v_q || out_valid_q;
  assign beat   = iInValid && !iClear;
  // A beat in the same cycle blocks writes so it always sees the old weights.
  assign cfg_ok = !busy && !iInValid;

  always_comb begin
    ch_d = ch_q;
    if (iClear)        ch_d = '0;
    else if (iInValid) ch_d = (ch_q == CW'(CIN - 1)) ? '0 : ch_q + 1'b1;

    err_d = err_q;
    if (iClear)                                 err_d = 1'b0;
    else if ((iWeightWe || iBiasWe) && !cfg_ok) err_d = 1'b1;

    for (int i = 0; i < NW; i++) begin
      w_d[i] = w_q[i];
      if (cfg_ok && iWeightWe && (iWeightAddr == AW'(i))) w_d[i] = iWeightData;
    end
    bias_d = bias_q;
    if (cfg_ok && iBiasWe) bias_d = iBiasData;
  end

  always_comb begin
    s1_v_d     = beat;
    s1_first_d = s1_first_q;
    s1_last_d  = s1_last_q;
    s1_relu_d  = s1_relu_q;
    a_e        = '0;
    b_e        = '0;
    for (int i = 0; i < NT; i++) prod_d[i] = prod_q[i];
    if (beat) begin
      s1_first_d = (ch_q == '0);
      s1_last_d  = (ch_q == CW'(CIN - 1));
      s1_relu_d  = iRelu;
      for (int i = 0; i < NT; i++) begin
        a_e       = iWindow[(NT-1-i)*WI +: WI];
        b_e       = w_q[int'(ch_q)*NT + i];
        prod_d[i] = $signed({{WI{a_e[WI-1]}}, a_e}) * $signed({{WI{b_e[WI-1]}}, b_e});
      end
    end
    for (int i = 0; i < NT; i++) prod_flat[i*PW +: PW] = prod_q[i];
  end

  conv_adder_tree #(
    .N    (NT),
    .PW   (PW),
    .ACCW (ACCW)
  ) u_tree (
    .iClk  (iClk),
    .iRst  (iRst),
    .iEn   (s1_v_q),
    .iProd (prod_flat),
    .oSum  (tree_sum)
  );

  always_comb begin
    s2_v_d     = s1_v_q && !iClear;
    s2_first_d = s1_v_q ? s1_first_q : s2_first_q;
    s2_last_d  = s1_v_q ? s1_last_q  : s2_last_q;
    s2_relu_d  = s1_v_q ? s1_relu_q  : s2_relu_q;

    acc_next  = s2_first_q ? tree_sum : acc_q + tree_sum;
    biased    = acc_next + ACCW'(bias_q);
    shifted   = biased >>> SHIFT;
    rectified = (s2_relu_q && shifted < 0) ? '0 : shifted;

    acc_d       = acc_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    sat_d       = sat_q;
    if (s2_v_q && !iClear) begin
      acc_d = acc_next;
      if (s2_last_q) begin
        out_valid_d = 1'b1;
        sat_d       = 1'b0;
        out_data_d  = OUTW'(rectified);
        if (longint'(rectified) > OUT_MAX) begin
          out_data_d = OUTW'(OUT_MAX);
          sat_d      = 1'b1;
        end else if (longint'(rectified) < OUT_MIN) begin
          out_data_d = OUTW'(OUT_MIN);
          sat_d      = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      for (int i = 0; i < NW; i++) w_q[i] <= '0;
      for (int i = 0; i < NT; i++) prod_q[i] <= '0;
      bias_q      <= '0;
      ch_q        <= '0;
      s1_v_q      <= 1'b0;
      s1_first_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_relu_q   <= 1'b0;
      s2_v_q      <= 1'b0;
      s2_first_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      s2_relu_q   <= 1'b0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      sat_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      for (int i = 0; i < NW; i++) w_q[i] <= w_d[i];
      for (int i = 0; i < NT; i++) prod_q[i] <= prod_d[i];
      bias_q      <= bias_d;
      ch_q        <= ch_d;
      s1_v_q      <= s1_v_d;
      s1_first_q  <= s1_first_d;
      s1_last_q   <= s1_last_d;
      s1_relu_q   <= s1_relu_d;
      s2_v_q      <= s2_v_d;
      s2_first_q  <= s2_first_d;
      s2_last_q   <= s2_last_d;
      s2_relu_q   <= s2_relu_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      sat_q       <= sat_d;
      err_q       <= err_d;
    end
  end

  assign oOutValid = out_valid_q;
  assign oOutData  = out_data_q;
  assign oSat      = sat_q;
  assign oBusy     = busy;
  assign oCfgErr   = err_q;

endmodule

// File: tb/tb_conv_kxk_mac.sv
// Randomized and directed bench for conv_kxk_mac against an arithmetic
// dot-product model with an expected-result queue.
module tb_conv_kxk_mac;

  localparam int WI = 8, K = 3, CIN = 2, BW = 32, ACCW = 32, OUTW = 16, SHIFT = 0;
  localparam int NT = K * K;
  localparam int AW = 5;

  logic                   iClk = 1'b0;
  logic                   iRst, iClear, iInValid, iRelu, iWeightWe, iBiasWe;
  logic [NT*WI-1:0]       iWindow;
  logic [AW-1:0]          iWeightAddr;
  logic [WI-1:0]          iWeightData;
  logic [BW-1:0]          iBiasData;
  logic                   oOutValid, oSat, oBusy, oCfgErr;
  logic signed [OUTW-1:0] oOutData;

  conv_kxk_mac #(
    .WI(WI), .K(K), .CIN(CIN), .BW(BW), .ACCW(ACCW), .OUTW(OUTW), .SHIFT(SHIFT)
  ) dut (
    .iClk(iClk), .iRst(iRst), .iClear(iClear), .iInValid(iInValid),
    .iWindow(iWindow), .iRelu(iRelu), .iWeightWe(iWeightWe),
    .iWeightAddr(iWeightAddr), .iWeightData(iWeightData),
    .iBiasWe(iBiasWe), .iBiasData(iBiasData), .oOutValid(oOutValid),
    .oOutData(oOutData), .oSat(oSat), .oBusy(oBusy), .oCfgErr(oCfgErr)
  );

  // clock / reset
  always #5 iClk = ~iClk;
  int cyc = 0;
  always @(posedge iClk) cyc <= cyc + 1;

  // reference model state
  int mw [CIN*NT];
  int mbias, m_ch, m_acc;
  int win [NT];
  logic [OUTW:0] exp_q [$];
  int            lat_q [$];
  int n_cmp = 0, n_err = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_beat(input bit relu);
    int dot, y;
    bit s;
    dot = 0;
    s   = 1'b0;
    for (int i = 0; i < NT; i++) dot += win[i] * mw[m_ch*NT + i];
    if (m_ch == 0) m_acc = dot;
    else           m_acc = m_acc + dot;
    if (m_ch == CIN - 1) begin
      y = (m_acc + mbias) >>> SHIFT;
      if (relu && y < 0) y = 0;
      if (y > 32767)       begin y = 32767;  s = 1'b1; end
      else if (y < -32768) begin y = -32768; s = 1'b1; end
      exp_q.push_back({s, 16'(y)});
      lat_q.push_back(cyc + 3);
      m_ch = 0;
    end else begin
      m_ch++;
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge iClk);
    #1;
    iInValid  = 1'b0;
    iWeightWe = 1'b0;
    iBiasWe   = 1'b0;
    iClear    = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic wr_w(input int addr, input int data, input bit ok);
    iWeightWe   = 1'b1;
    iWeightAddr = addr[AW-1:0];
    iWeightData = data[WI-1:0];
    if (ok) mw[addr] = data;
    tick();
  endtask

  task automatic wr_b(input int data, input bit ok);
    iBiasWe   = 1'b1;
    iBiasData = data;
    if (ok) mbias = data;
    tick();
  endtask

  task automatic load_all(input int wv, input int bv);
    for (int i = 0; i < CIN*NT; i++) wr_w(i, wv, 1'b1);
    wr_b(bv, 1'b1);
  endtask

  task automatic load_rand(input int bmax);
    for (int i = 0; i < CIN*NT; i++) wr_w(i, int'($urandom_range(0, 255)) - 128, 1'b1);
    wr_b(int'($urandom_range(0, 2*bmax)) - bmax, 1'b1);
  endtask

  task automatic fill(input int v);
    for (int i = 0; i < NT; i++) win[i] = v;
  endtask

  task automatic rand_win();
    for (int i = 0; i < NT; i++) win[i] = int'($urandom_range(0, 255)) - 128;
  endtask

  // with_wr drives a weight write alongside the beat; it must be rejected
  task automatic beat(input bit relu, input bit with_wr);
    for (int i = 0; i < NT; i++) iWindow[(NT-1-i)*WI +: WI] = win[i][WI-1:0];
    iInValid = 1'b1;
    iRelu    = relu;
    if (with_wr) begin
      iWeightWe   = 1'b1;
      iWeightAddr = '0;
      iWeightData = 8'd77;
    end
    model_beat(relu);
    tick();
  endtask

  task automatic wait_idle();
    idle(5);
    check("busy_idle", oBusy, 0);
  endtask

  // scoreboard
  always @(negedge iClk) begin
    logic [OUTW:0] e;
    int            l;
    if (!iRst && oOutValid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", 1, 0);
      end else begin
        e = exp_q.pop_front();
        l = lat_q.pop_front();
        check("out_sat_data", {oSat, oOutData}, e);
        check("latency", cyc, l);
      end
    end
  end

  initial begin
    iRst = 1'b1; iClear = 1'b0; iInValid = 1'b0; iRelu = 1'b0;
    iWeightWe = 1'b0; iBiasWe = 1'b0; iWindow = '0;
    iWeightAddr = '0; iWeightData = '0; iBiasData = '0;
    for (int i = 0; i < CIN*NT; i++) mw[i] = 0;
    mbias = 0; m_ch = 0; m_acc = 0;

    repeat (3) @(posedge iClk);
    #1;
    check("rst_valid", oOutValid, 0);
    check("rst_data", oOutData, 0);
    check("rst_sat", oSat, 0);
    check("rst_busy", oBusy, 0);
    check("rst_err", oCfgErr, 0);
    iRst = 1'b0;
    idle(2);

    // all ones -> 18, then held
    load_all(1, 0);
    fill(1);
    beat(0, 0); beat(0, 0);
    wait_idle();
    idle(3);
    check("hold_data", oOutData, 18);
    check("hold_sat", oSat, 0);

    // negative weights, with and without ReLU
    load_all(-1, 0);
    fill(10);
    beat(0, 0); beat(0, 0);
    beat(0, 0); beat(1, 0);
    wait_idle();

    // saturation both ways
    load_all(127, 0);
    fill(127);
    beat(0, 0); beat(0, 0);
    wait_idle();
    load_all(-128, 0);
    beat(0, 0); beat(0, 0);
    wait_idle();

    // four beats with a gap after beat 1
    load_rand(1000);
    rand_win(); beat(0, 0);
    idle(1);
    rand_win(); beat(0, 0);
    rand_win(); beat(0, 0);
    rand_win(); beat(1, 0);
    wait_idle();

    // write while busy is rejected and sticky until clear
    rand_win(); beat(0, 0);
    wr_w(0, 5, 1'b0);
    check("err_busy_wr", oCfgErr, 1);
    rand_win(); beat(0, 0);
    wait_idle();
    check("err_sticky", oCfgErr, 1);
    iClear = 1'b1;
    tick();
    check("err_cleared", oCfgErr, 0);
    wr_w(0, 5, 1'b1);
    rand_win(); beat(0, 0);
    rand_win(); beat(0, 0);
    wait_idle();
    check("err_after_good_wr", oCfgErr, 0);

    // write coincident with a beat while idle
    rand_win(); beat(0, 1);
    check("err_wr_with_beat", oCfgErr, 1);
    rand_win(); beat(0, 0);
    wait_idle();
    iClear = 1'b1;
    tick();
    check("err_cleared2", oCfgErr, 0);

    // clear beats a simultaneous beat; it is dropped
    rand_win();
    iWindow  = '1;
    iInValid = 1'b1;
    iClear   = 1'b1;
    tick();
    check("clear_drop_busy", oBusy, 0);
    rand_win(); beat(0, 0);
    rand_win(); beat(1, 0);
    wait_idle();

    // randomized traffic with gaps
    load_rand(20000);
    for (int n = 0; n < 12; n++) begin
      for (int c = 0; c < CIN; c++) begin
        rand_win();
        beat(1'($urandom_range(0, 1)), 0);
        idle(int'($urandom_range(0, 2)));
      end
    end
    wait_idle();

    // reset mid-accumulation
    rand_win(); beat(0, 0);
    idle(1);
    iRst = 1'b1;
    #1;
    check("midrst_valid", oOutValid, 0);
    check("midrst_data", oOutData, 0);
    check("midrst_sat", oSat, 0);
    check("midrst_busy", oBusy, 0);
    check("midrst_err", oCfgErr, 0);
    for (int i = 0; i < CIN*NT; i++) mw[i] = 0;
    mbias = 0; m_ch = 0; m_acc = 0;
    @(posedge iClk);
    #1;
    iRst = 1'b0;
    idle(6);
    load_all(2, 5);
    fill(3);
    beat(0, 0); beat(0, 0);
    wait_idle();

    begin
      int budget;
      budget = 0;
      while (exp_q.size() != 0 && budget < 20) begin
        tick();
        budget++;
      end
    end
    check("drain", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
